// File: rtl/traffic_pkg.sv
// Shared encodings for the country-road detector and the sig_control light controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } db_state_e;

endpackage

// File: rtl/car_detector_if.sv
// Sensor/light inputs and request/status outputs of the car detector.
interface car_detector_if #(
    parameter int CNT_W = 4
);
    logic             loop_raw;
    logic [1:0]       cntry;
    logic             X;
    logic             present;
    logic [CNT_W-1:0] car_count;
    logic             overflow;

    modport master (
        output loop_raw, cntry,
        input  X, present, car_count, overflow
    );

    modport slave (
        input  loop_raw, cntry,
        output X, present, car_count, overflow
    );
endinterface

// File: rtl/sig_debounce.sv
// Two-flop synchronizer plus LOW/RISE/HIGH/FALL debounce FSM for the loop sensor.
module sig_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic loop_raw,
    output logic present,
    output logic rise,
    output logic fall
);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] DB_LAST = SW'(DEBOUNCE);

    logic          s1_q, s2_q;
    db_state_e     state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          present_q, present_d;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            s1_q      <= FALSE;
            s2_q      <= FALSE;
            state_q   <= LOW;
            cnt_q     <= '0;
            present_q <= FALSE;
        end else begin
            s1_q      <= loop_raw;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            present_q <= present_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        present_d = present_q;
        unique case (state_q)
            LOW, HIGH: begin
                if (s2_q != present_q) begin
                    // A single-cycle debounce accepts the change immediately.
                    if (DEBOUNCE == 1) begin
                        present_d = ~present_q;
                        state_d   = (state_q == LOW) ? HIGH : LOW;
                        cnt_d     = '0;
                    end else begin
                        state_d = (state_q == LOW) ? RISE : FALL;
                        cnt_d   = SW'(1);
                    end
                end
            end
            RISE, FALL: begin
                if (s2_q == present_q) begin
                    state_d = (state_q == RISE) ? LOW : HIGH;
                    cnt_d   = '0;
                end else if (cnt_q + SW'(1) == DB_LAST) begin
                    present_d = ~present_q;
                    state_d   = (state_q == RISE) ? HIGH : LOW;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes lead the registered presence so the queue updates on the same edge.
    assign rise    = present_d & ~present_q;
    assign fall    = ~present_d & present_q;
    assign present = present_q;
endmodule

// File: rtl/car_detector.sv
// Queue counter, gap-timeout flush and sticky overflow feeding the car-waiting request X.
module car_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int GAP      = 8,
    parameter int CNT_W    = 4
) (
    input  logic          clock,
    input  logic          clear_n,
    car_detector_if.slave bus
);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             present, rise, fall;
    logic             is_green, flush;
    logic [GW-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    sig_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clock    (clock),
        .clear_n  (clear_n),
        .loop_raw (bus.loop_raw),
        .present  (present),
        .rise     (rise),
        .fall     (fall)
    );

    // Code 3 is not a valid light and is treated like any non-GREEN code.
    assign is_green = (bus.cntry == GREEN);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            gap_q   <= '0;
            count_q <= '0;
            ovf_q   <= FALSE;
        end else begin
            gap_q   <= gap_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        gap_d   = gap_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        flush   = FALSE;

        if (present || !is_green) begin
            gap_d = '0;
        end else if (gap_q + GW'(1) == GAP_LAST) begin
            gap_d = '0;
            flush = TRUE;
        end else begin
            gap_d = gap_q + GW'(1);
        end

        // Flush first so a same-cycle arrival leaves exactly one car queued.
        if (flush) count_d = '0;

        if (rise) begin
            if (count_d == CNT_MAX) ovf_d = TRUE;
            else                    count_d = count_d + CNT_W'(1);
        end else if (fall && is_green && (count_d != '0)) begin
            count_d = count_d - CNT_W'(1);
        end
    end

    assign bus.X         = (count_q != '0);
    assign bus.present   = present;
    assign bus.car_count = count_q;
    assign bus.overflow  = ovf_q;
endmodule
